// File: rtl/or_16_bist.sv
// Built-in self-test driver/checker for a 16-bit OR datapath: applies a fixed
// and LFSR vector set, compares each result against a|b, and reports pass/err_count.
// Optional first-failure capture is enabled by defining OR16_BIST_FIRST_FAIL_EN.
module or_16_bist #(
    parameter int          NUM_VECTORS = 64,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [15:0] dut_a,
    output logic [15:0] dut_b,
    input  logic [15:0] dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count
`ifdef OR16_BIST_FIRST_FAIL_EN
    ,
    output logic [9:0]  fail_index,
    output logic [15:0] fail_expect
`endif
);

    // state   | meaning
    // S_IDLE  | waiting for start after reset
    // S_APPLY | register operands for vec_idx onto dut_a/dut_b
    // S_CHECK | operands settled for a full cycle; compare dut_out
    // S_DONE  | run finished; results frozen until next start
    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [9:0] LAST_IDX  = 10'(NUM_VECTORS - 1);
    localparam logic [9:0] FIXED_CNT = 10'd6;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic [9:0]  vec_idx;
    logic [15:0] lfsr;
    logic [15:0] vec_a;
    logic [15:0] vec_b;
    logic [15:0] expected;
    logic        mismatch;
    logic [7:0]  err_nxt;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                busy      = 1'b1;
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                busy      = 1'b1;
                state_nxt = (vec_idx < LAST_IDX) ? S_APPLY : S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_APPLY;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Directed corner vectors first, then pseudo-random pairs from the LFSR.
    always_comb begin
        vec_a = lfsr;
        vec_b = lfsr_step(lfsr);
        case (vec_idx)
            10'd0: begin vec_a = 16'h0000; vec_b = 16'h0000; end
            10'd1: begin vec_a = 16'h0000; vec_b = 16'hFFFF; end
            10'd2: begin vec_a = 16'hFFFF; vec_b = 16'hFFFF; end
            10'd3: begin vec_a = 16'hAAAA; vec_b = 16'h5555; end
            10'd4: begin vec_a = 16'h3CC3; vec_b = 16'h0FF0; end
            10'd5: begin vec_a = 16'h1234; vec_b = 16'h9876; end
            default: ;
        endcase
    end

    always_comb begin
        expected = dut_a | dut_b;
        mismatch = (state == S_CHECK) && (dut_out != expected);
        err_nxt  = err_count;
        if (mismatch && (err_count != 8'hFF)) err_nxt = err_count + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dut_a     <= 16'h0000;
            dut_b     <= 16'h0000;
            pass      <= 1'b0;
            err_count <= 8'h00;
            vec_idx   <= 10'd0;
            lfsr      <= SEED;
        end else if (accept) begin
            pass      <= 1'b0;
            err_count <= 8'h00;
            vec_idx   <= 10'd0;
            lfsr      <= SEED;
        end else if (state == S_APPLY) begin
            dut_a <= vec_a;
            dut_b <= vec_b;
            if (vec_idx >= FIXED_CNT) lfsr <= lfsr_step(lfsr_step(lfsr));
        end else if (state == S_CHECK) begin
            err_count <= err_nxt;
            vec_idx   <= vec_idx + 10'd1;
            if (state_nxt == S_DONE) pass <= (err_nxt == 8'h00);
        end
    end

`ifdef OR16_BIST_FIRST_FAIL_EN
    logic fail_seen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_seen   <= 1'b0;
            fail_index  <= 10'd0;
            fail_expect <= 16'h0000;
        end else if (accept) begin
            fail_seen   <= 1'b0;
            fail_index  <= 10'd0;
            fail_expect <= 16'h0000;
        end else if (mismatch && !fail_seen) begin
            fail_seen   <= 1'b1;
            fail_index  <= vec_idx;
            fail_expect <= expected;
        end
    end
`endif

endmodule
